// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle type, sequencer state type and the
// quarter-wave cosine helper used to build the twiddle ROM.
package fft_pkg;

  localparam int  N     = 512;     // FFT points
  localparam int  LOG2N = 9;       // log2(N)
  localparam int  TW_W  = 9;       // signed twiddle width, Q1.7 (+1.0 = +128)
  localparam int  AW    = LOG2N - 2;  // quarter-wave ROM address width
  localparam real PI    = 3.14159265358979323846;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // round(128*cos(2*pi*k/N)), half away from zero; magnitude fits 8 bits
  function automatic logic [7:0] quarter_cos(input int k);
    real x;
    int  r;
    x = 128.0 * $cos(2.0 * PI * real'(k) / real'(N));
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else          r = -$rtoi(-x + 0.5);
    if (r < 0) r = 0;
    return 8'(r);
  endfunction

endpackage

// File: rtl/tw_rom.sv
// Quarter-wave C/S twiddle table with a registered read. The register also
// applies the sign/swap selection and the unity override, so its output is
// the final twiddle presented to the multiplier.
module tw_rom
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic          upper,
  input  logic          unity,
  output tw_t           tw
);

  localparam logic signed [TW_W-1:0] ONE = TW_W'(128);

  logic [7:0] c_tab [N/4];
  logic [7:0] s_tab [N/4];

  // Table contents are elaboration-time constants; S[k] = C[N/4-k]
  for (genvar k = 0; k < N/4; k++) begin : g_tab
    assign c_tab[k] = quarter_cos(k);
    assign s_tab[k] = quarter_cos(N/4 - k);
  end

  logic signed [TW_W-1:0] c_v;
  logic signed [TW_W-1:0] s_v;

  // Zero-extend the unsigned magnitudes to the signed output width
  always_comb begin
    c_v = TW_W'(c_tab[addr]);
    s_v = TW_W'(s_tab[addr]);
  end

  // P2: registered read with sign/swap; holds when no valid sample arrives
  // NOTE: the tables are constants and carry no reset; only this read register is cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tw <= '0;
    end else if (en) begin
      if (unity) begin
        tw.re <= ONE;
        tw.im <= '0;
      end else if (upper) begin
        tw.re <= -s_v;
        tw.im <= -c_v;
      end else begin
        tw.re <= c_v;
        tw.im <= -s_v;
      end
    end
  end

endmodule

// File: rtl/tw_gen.sv
// Twiddle-factor sequencer for one radix-2 DIF SDF stage. Tracks the sample
// index within a frame, folds it onto a quarter-wave ROM address and emits
// the twiddle with valid/sop/eop aligned to a 2-cycle data path.
module tw_gen
  import fft_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic                   in_sop,
  output logic signed [TW_W-1:0] tw_re,
  output logic signed [TW_W-1:0] tw_im,
  output logic                   tw_valid,
  output logic                   tw_sop,
  output logic                   tw_eop,
  output logic                   sync_err
);

  localparam int               HALF_BIT = LOG2N - 1 - STAGE;  // selects b >= L/2
  localparam logic [LOG2N-1:0] LAST     = LOG2N'(N - 1);

  state_t           state, state_n;
  logic [LOG2N-1:0] cnt, cnt_n, idx;
  logic             emit, sop, eop, err;
  logic [LOG2N-2:0] e;
  logic             unity_c;

  logic [AW-1:0]    addr1;
  logic             upper1, unity1, v1, sop1, eop1, err1;
  tw_t              tw_q;

  // Next-state, counter update and the index emitted this cycle
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx     = cnt;
    emit    = 1'b0;
    sop     = 1'b0;
    eop     = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_sop) begin
            emit    = 1'b1;
            sop     = 1'b1;
            idx     = '0;
            cnt_n   = LOG2N'(1);
            state_n = RUN;
          end else begin
            err = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          emit = 1'b1;
          if (in_sop) begin
            sop   = 1'b1;
            err   = 1'b1;
            idx   = '0;
            cnt_n = LOG2N'(1);
          end else if (cnt == LAST) begin
            eop     = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Address folding: e = (b - L/2) << STAGE drops the block bits above L/2
  assign e       = (LOG2N-1)'(idx << STAGE);
  assign unity_c = ~idx[HALF_BIT];

  // FSM state and sample counter
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // P1: folded address, quadrant/unity flags and framing strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr1  <= '0;
      upper1 <= 1'b0;
      unity1 <= 1'b0;
      v1     <= 1'b0;
      sop1   <= 1'b0;
      eop1   <= 1'b0;
      err1   <= 1'b0;
    end else begin
      v1   <= emit;
      sop1 <= sop;
      eop1 <= eop;
      err1 <= err;
      if (emit) begin
        addr1  <= e[AW-1:0];
        upper1 <= e[LOG2N-2];
        unity1 <= unity_c;
      end
    end
  end

  // P2: framing strobes aligned with the registered ROM read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tw_valid <= 1'b0;
      tw_sop   <= 1'b0;
      tw_eop   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      tw_valid <= v1;
      tw_sop   <= sop1;
      tw_eop   <= eop1;
      sync_err <= err1;
    end
  end

  tw_rom u_rom (
    .clk   (clk),
    .rstn  (rstn),
    .en    (v1),
    .addr  (addr1),
    .upper (upper1),
    .unity (unity1),
    .tw    (tw_q)
  );

  assign tw_re = tw_q.re;
  assign tw_im = tw_q.im;

endmodule

// File: tb/tb_tw_gen.sv
// Self-checking bench for tw_gen: a STAGE=0 and a STAGE=2 instance share the
// stimulus and are compared every cycle against a frame/twiddle model.
module tb_tw_gen;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;

  logic signed [TW_W-1:0] tw_re0, tw_im0, tw_re2, tw_im2;
  logic tw_valid0, tw_sop0, tw_eop0, sync_err0;
  logic tw_valid2, tw_sop2, tw_eop2, sync_err2;

  int checks = 0;
  int errors = 0;

  tw_gen #(.STAGE(0)) u_s0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sop(in_sop),
    .tw_re(tw_re0), .tw_im(tw_im0), .tw_valid(tw_valid0),
    .tw_sop(tw_sop0), .tw_eop(tw_eop0), .sync_err(sync_err0)
  );

  tw_gen #(.STAGE(2)) u_s2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sop(in_sop),
    .tw_re(tw_re2), .tw_im(tw_im2), .tw_valid(tw_valid2),
    .tw_sop(tw_sop2), .tw_eop(tw_eop2), .sync_err(sync_err2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic v, sop, eop, err;
    int   idx;
    int   re0, im0, re2, im2;
  } exp_t;

  int   pos;                          // next frame index, -1 when no frame open
  int   h_re0, h_im0, h_re2, h_im2;   // held output values
  exp_t p1;                           // expectation in flight
  int   cyc, nvalid, nerr, nsop, sop_cyc, eop_cyc;
  int   cap0_re [N], cap0_im [N], cap2_re [N], cap2_im [N];
  int   ref0_re [N], ref0_im [N], ref2_re [N], ref2_im [N];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // W_N^e directly from the angle, with the unity region of each block
  task automatic ref_tw(input int i, input int stage, output int re, output int im);
    int  l, b, ex;
    real th;
    l = N >> stage;
    b = i % l;
    if (b < l / 2) begin
      re = 128;
      im = 0;
    end else begin
      ex = (b - l / 2) << stage;
      th = 2.0 * 3.14159265358979323846 * real'(ex) / real'(N);
      re = rnd(128.0 * $cos(th));
      im = -rnd(128.0 * $sin(th));
    end
  endtask

  task automatic model_reset();
    pos = -1;
    h_re0 = 0; h_im0 = 0; h_re2 = 0; h_im2 = 0;
    p1 = '{v: 1'b0, sop: 1'b0, eop: 1'b0, err: 1'b0, idx: 0, re0: 0, im0: 0, re2: 0, im2: 0};
  endtask

  task automatic clear_stats();
    cyc = 0; nvalid = 0; nerr = 0; nsop = 0; sop_cyc = -1; eop_cyc = -1;
    for (int i = 0; i < N; i++) begin
      cap0_re[i] = 999; cap0_im[i] = 999; cap2_re[i] = 999; cap2_im[i] = 999;
    end
  endtask

  // One clock: drive inputs, predict, advance, compare both instances
  task automatic cycle(input logic v, input logic s);
    exp_t e, o;
    int   r, m;
    in_valid = v;
    in_sop   = s;
    e = '{v: 1'b0, sop: 1'b0, eop: 1'b0, err: 1'b0, idx: 0, re0: 0, im0: 0, re2: 0, im2: 0};
    if (v) begin
      if (s) begin
        e.err = (pos > 0);
        e.v = 1'b1; e.sop = 1'b1; e.idx = 0;
        pos = 1;
      end else if (pos < 0) begin
        e.err = 1'b1;
      end else begin
        e.v = 1'b1; e.idx = pos;
        if (pos == N - 1) begin
          e.eop = 1'b1;
          pos = -1;
        end else begin
          pos = pos + 1;
        end
      end
    end
    if (e.v) begin
      ref_tw(e.idx, 0, r, m); h_re0 = r; h_im0 = m;
      ref_tw(e.idx, 2, r, m); h_re2 = r; h_im2 = m;
    end
    e.re0 = h_re0; e.im0 = h_im0; e.re2 = h_re2; e.im2 = h_im2;

    @(posedge clk);
    o  = p1;
    p1 = e;
    cyc++;
    #1;
    checks++;
    if (tw_valid0 !== o.v || tw_sop0 !== o.sop || tw_eop0 !== o.eop || sync_err0 !== o.err ||
        int'(tw_re0) != o.re0 || int'(tw_im0) != o.im0) begin
      errors++;
      $display("FAIL s0_out cyc=%0d got v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) want v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) idx=%0d",
               cyc, tw_valid0, tw_sop0, tw_eop0, sync_err0, tw_re0, tw_im0,
               o.v, o.sop, o.eop, o.err, o.re0, o.im0, o.idx);
    end
    checks++;
    if (tw_valid2 !== o.v || tw_sop2 !== o.sop || tw_eop2 !== o.eop || sync_err2 !== o.err ||
        int'(tw_re2) != o.re2 || int'(tw_im2) != o.im2) begin
      errors++;
      $display("FAIL s2_out cyc=%0d got v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) want v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) idx=%0d",
               cyc, tw_valid2, tw_sop2, tw_eop2, sync_err2, tw_re2, tw_im2,
               o.v, o.sop, o.eop, o.err, o.re2, o.im2, o.idx);
    end
    if (tw_valid0 === 1'b1) begin
      nvalid++;
      cap0_re[o.idx] = int'(tw_re0); cap0_im[o.idx] = int'(tw_im0);
      cap2_re[o.idx] = int'(tw_re2); cap2_im[o.idx] = int'(tw_im2);
      if (tw_sop0 === 1'b1) begin nsop++; sop_cyc = cyc; end
      if (tw_eop0 === 1'b1) eop_cyc = cyc;
    end
    if (sync_err0 === 1'b1) nerr++;
  endtask

  task automatic drain();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, i == 0);
  endtask

  // Aggregate capture comparison against the saved clean-frame result
  task automatic cmp_caps(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++)
      if (cap0_re[i] != ref0_re[i] || cap0_im[i] != ref0_im[i] ||
          cap2_re[i] != ref2_re[i] || cap2_im[i] != ref2_im[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s got %0d differing indices want 0", name, bad);
    end
    checks++;
    if (nvalid != N) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, nvalid, N);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_sop = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tw_valid0, tw_sop0, tw_eop0, sync_err0, tw_re0, tw_im0} !== '0) begin
      errors++;
      $display("FAIL reset_s0 got v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) want all 0",
               tw_valid0, tw_sop0, tw_eop0, sync_err0, tw_re0, tw_im0);
    end
    checks++;
    if ({tw_valid2, tw_sop2, tw_eop2, sync_err2, tw_re2, tw_im2} !== '0) begin
      errors++;
      $display("FAIL reset_s2 got v=%b sop=%b eop=%b err=%b tw=(%0d,%0d) want all 0",
               tw_valid2, tw_sop2, tw_eop2, sync_err2, tw_re2, tw_im2);
    end
    rstn = 1'b1;
    clear_stats();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (nerr != 1 || sync_err0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_nosop_err got pulses=%0d err_at_2=%b want 1 and 1", nerr, sync_err0);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (nvalid != 0 || nerr != 1) begin
      errors++;
      $display("FAIL reset_nosop_drop got valid=%0d pulses=%0d want 0 and 1", nvalid, nerr);
    end
  endtask

  task automatic test_full_frame();
    int bad;
    clear_stats();
    frame(N);
    drain();
    bad = 0;
    for (int i = 0; i <= 256; i++) if (cap0_re[i] != 128 || cap0_im[i] != 0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL s0_unity got %0d bad indices want 0", bad); end
    checks++;
    if (cap0_re[320] != 91 || cap0_im[320] != -91) begin
      errors++; $display("FAIL s0_i320 got (%0d,%0d) want (91,-91)", cap0_re[320], cap0_im[320]);
    end
    checks++;
    if (cap0_re[384] != 0 || cap0_im[384] != -128) begin
      errors++; $display("FAIL s0_i384 got (%0d,%0d) want (0,-128)", cap0_re[384], cap0_im[384]);
    end
    checks++;
    if (cap0_re[448] != -91 || cap0_im[448] != -91) begin
      errors++; $display("FAIL s0_i448 got (%0d,%0d) want (-91,-91)", cap0_re[448], cap0_im[448]);
    end
    checks++;
    if (sop_cyc != 2 || eop_cyc != 513) begin
      errors++; $display("FAIL frame_timing got sop@%0d eop@%0d want sop@2 eop@513", sop_cyc, eop_cyc);
    end
    checks++;
    if (nvalid != N || nerr != 0) begin
      errors++; $display("FAIL frame_count got valid=%0d err=%0d want %0d and 0", nvalid, nerr, N);
    end
    for (int i = 0; i < N; i++) begin
      ref0_re[i] = cap0_re[i]; ref0_im[i] = cap0_im[i];
      ref2_re[i] = cap2_re[i]; ref2_im[i] = cap2_im[i];
    end
  endtask

  task automatic test_stage2();
    int bad;
    clear_stats();
    frame(N);
    drain();
    checks++;
    if (cap2_re[96] != 0 || cap2_im[96] != -128) begin
      errors++; $display("FAIL s2_i96 got (%0d,%0d) want (0,-128)", cap2_re[96], cap2_im[96]);
    end
    checks++;
    if (cap2_re[80] != 91 || cap2_im[80] != -91) begin
      errors++; $display("FAIL s2_i80 got (%0d,%0d) want (91,-91)", cap2_re[80], cap2_im[80]);
    end
    checks++;
    if (cap2_re[128] != 128 || cap2_im[128] != 0) begin
      errors++; $display("FAIL s2_i128 got (%0d,%0d) want (128,0)", cap2_re[128], cap2_im[128]);
    end
    bad = 0;
    for (int i = 0; i < N - 128; i++)
      if (cap2_re[i] != cap2_re[i + 128] || cap2_im[i] != cap2_im[i + 128]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL s2_period got %0d bad indices want 0", bad); end
  endtask

  task automatic test_gaps();
    int k, n;
    logic v, s;
    clear_stats();
    k = 0;
    n = 0;
    while (k < N && n < 20000) begin
      v = 1'($urandom_range(0, 1));
      s = v ? (k == 0) : 1'($urandom_range(0, 1));
      cycle(v, s);
      if (v) k++;
      n++;
    end
    drain();
    checks++;
    if (k != N) begin errors++; $display("FAIL gaps_budget got %0d samples want %0d", k, N); end
    cmp_caps("gaps");
  endtask

  task automatic test_framing();
    clear_stats();
    for (int i = 0; i < 100; i++) cycle(1'b1, i == 0);
    frame(N);          // in_sop at i=100 restarts the frame
    frame(N);          // back-to-back frame, sop right after eop
    drain();
    checks++;
    if (nerr != 1) begin errors++; $display("FAIL framing_err got %0d pulses want 1", nerr); end
    checks++;
    if (nsop != 3 || nvalid != 100 + 2 * N) begin
      errors++; $display("FAIL framing_count got sop=%0d valid=%0d want 3 and %0d", nsop, nvalid, 100 + 2 * N);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    for (int i = 0; i < 200; i++) cycle(1'b1, i == 0);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({tw_valid0, tw_sop0, tw_eop0, sync_err0, tw_re0, tw_im0,
         tw_valid2, tw_sop2, tw_eop2, sync_err2, tw_re2, tw_im2} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got s0 v=%b tw=(%0d,%0d) s2 v=%b tw=(%0d,%0d) want all 0",
               tw_valid0, tw_re0, tw_im0, tw_valid2, tw_re2, tw_im2);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_stats();
    frame(N);
    drain();
    cmp_caps("reset_mid");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stage2();
    test_gaps();
    test_framing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
